// File: rtl/oam_dma_ctrl_pkg.sv
// rtl/oam_dma_ctrl_pkg.sv - shared defines for the sprite OAM DMA controller
package oam_dma_ctrl_pkg;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_HALT,
        DMA_ALIGN,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

    // CPU write to this address starts a transfer; decoded in cpu_memory.
    localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

    function automatic logic [7:0] last_idx(input int unsigned len);
        return 8'(len - 1);
    endfunction

endpackage

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - sequences the $4014 sprite DMA from CPU page into PPU OAMDATA
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter int unsigned XFER_LEN = 256,
    parameter logic        READ_PAR = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cpu_clk_en,
    input  logic        cpu_cyc_par,
    input  logic        dma_req,
    input  logic [7:0]  dma_page,
    output logic        cpu_sus,
    output logic [15:0] mem_addr,
    output logic        mem_re,
    input  logic [7:0]  mem_rd_data,
    output logic        oam_we,
    output logic [7:0]  oam_data,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST_IDX = last_idx(XFER_LEN);

    dma_state_t state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] page_q, page_d;
    logic       done_q, done_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DMA_IDLE;
            idx_q   <= 8'h00;
            page_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        page_d  = page_q;
        done_d  = done_q;
        if (cpu_clk_en) begin
            done_d = 1'b0;
            case (state_q)
                DMA_IDLE: begin
                    if (dma_req) begin
                        page_d  = dma_page;
                        idx_d   = 8'h00;
                        state_d = DMA_HALT;
                    end
                end
                // Reads must land on READ_PAR cycles; insert ALIGN when the next cycle is wrong.
                DMA_HALT:  state_d = ((~cpu_cyc_par) == READ_PAR) ? DMA_READ : DMA_ALIGN;
                DMA_ALIGN: state_d = DMA_READ;
                DMA_READ:  state_d = DMA_WRITE;
                DMA_WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DMA_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 8'h01;
                        state_d = DMA_READ;
                    end
                end
                default: state_d = DMA_IDLE;
            endcase
        end
    end

    assign cpu_sus  = (state_q != DMA_IDLE);
    assign busy     = cpu_sus;
    assign mem_re   = (state_q == DMA_READ);
    assign mem_addr = mem_re ? {page_q, idx_q} : 16'h0000;
    assign oam_we   = (state_q == DMA_WRITE);
    assign oam_data = oam_we ? mem_rd_data : 8'h00;
    assign done     = done_q;

endmodule
